// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, driven by the pipeline controller's command bus.
`ifndef CTRL_Wire_Bus
`define CTRL_Wire_Bus 1:0
`endif
`ifndef CTRL_STATE_Default
`define CTRL_STATE_Default 2'b00
`endif
`ifndef CTRL_STATE_Block
`define CTRL_STATE_Block 2'b01
`endif
`ifndef CTRL_STATE_Bubble
`define CTRL_STATE_Bubble 2'b10
`endif
`ifndef CTRL_STATE_Branch
`define CTRL_STATE_Branch 2'b11
`endif

module muldiv_unit #(
  parameter int XLEN = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`CTRL_Wire_Bus] ctrl_signal_muldiv_i,
  input  logic                  muldiv_start_i,
  input  logic [2:0]            muldiv_op_i,
  input  logic                  muldiv_word_i,
  input  logic [XLEN-1:0]       muldiv_src1_i,
  input  logic [XLEN-1:0]       muldiv_src2_i,
  output logic                  muldiv_busy_o,
  output logic                  muldiv_ready_o,
  output logic [XLEN-1:0]       muldiv_result_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              word_q, word_d;
  logic              neg_q, neg_d;
  logic              negr_q, negr_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;

  logic              ctrl_def, abort, accept, is_div;
  logic              sgn1, sgn2, neg1, neg2, div0, ovf;
  logic [XLEN-1:0]   ext1, ext2, abs1, abs2, most_neg;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + XLEN'(1)) : v;
  endfunction

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic s);
    return {{(XLEN-32){s & v[31]}}, v[31:0]};
  endfunction

  // Upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
  function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   mcand);
    logic [XLEN:0] sum;
    sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    return {sum, acc[XLEN-1:1]};
  endfunction

  // Upper half is the partial remainder, lower half shifts dividend out and quotient in.
  function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   dvsr);
    logic [XLEN:0] rsh, diff;
    rsh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff = rsh - {1'b0, dvsr};
    if (diff[XLEN]) return {rsh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else            return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
  endfunction

  function automatic logic [XLEN-1:0] finalize(input logic [2*XLEN-1:0] acc,
                                               input logic [2:0] op, input logic word,
                                               input logic neg, input logic negr);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, res;
    // A 32-iteration word multiply leaves the product 32 bits up the accumulator.
    prod = word ? (acc >> 32) : acc;
    if (neg) prod = ~prod + (2*XLEN)'(1);
    quo = abs_val(acc[XLEN-1:0], neg);
    rem = abs_val(acc[2*XLEN-1:XLEN], negr);
    case (op)
      3'b000:                res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:        res = quo;
      default:               res = rem;
    endcase
    if (word) res = word_ext(res, 1'b1);
    return res;
  endfunction

  always_comb begin
    ctrl_def = (ctrl_signal_muldiv_i == `CTRL_STATE_Default);
    abort    = (ctrl_signal_muldiv_i == `CTRL_STATE_Bubble) ||
               (ctrl_signal_muldiv_i == `CTRL_STATE_Branch);
    accept   = (state_q == IDLE) && muldiv_start_i && ctrl_def;
    is_div   = muldiv_op_i[2];
    sgn1     = is_div ? ~muldiv_op_i[0] : (muldiv_op_i[1:0] != 2'b11);
    sgn2     = is_div ? ~muldiv_op_i[0] : ~muldiv_op_i[1];
    ext1     = muldiv_word_i ? word_ext(muldiv_src1_i, sgn1) : muldiv_src1_i;
    ext2     = muldiv_word_i ? word_ext(muldiv_src2_i, sgn2) : muldiv_src2_i;
    neg1     = sgn1 & ext1[XLEN-1];
    neg2     = sgn2 & ext2[XLEN-1];
    abs1     = abs_val(ext1, neg1);
    abs2     = abs_val(ext2, neg2);
    most_neg = muldiv_word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    div0     = (ext2 == '0);
    ovf      = sgn1 && (ext1 == most_neg) && (&ext2);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    negr_d   = negr_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d   = muldiv_op_i;
          word_d = muldiv_word_i;
          opb_d  = abs2;
          cnt_d  = muldiv_word_i ? CW'(32) : CW'(XLEN);
          neg_d  = neg1 ^ neg2;
          negr_d = neg1;
          state_d = CALC;
          if (is_div && div0) begin
            acc_d   = {ext1, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            cnt_d   = '0;
            state_d = DONE;
          end else if (is_div && ovf) begin
            acc_d   = {{XLEN{1'b0}}, ext1};
            neg_d   = 1'b0;
            negr_d  = 1'b0;
            cnt_d   = '0;
            state_d = DONE;
          end else if (is_div) begin
            acc_d = {{XLEN{1'b0}}, muldiv_word_i ? (abs1 << 32) : abs1};
          end else begin
            acc_d = {{XLEN{1'b0}}, abs1};
          end
        end
      end
      CALC: begin
        if (ctrl_def) begin
          acc_d = op_q[2] ? div_step(acc_q, opb_q) : mul_step(acc_q, opb_q);
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (ctrl_def) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
    // Result is captured only on the edge that enters DONE, from the final accumulator.
    if ((state_d == DONE) && (state_q != DONE))
      result_d = finalize(acc_d, op_d, word_d, neg_d, negr_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      negr_q   <= negr_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  assign muldiv_busy_o   = (state_q == CALC) || accept;
  assign muldiv_ready_o  = (state_q == DONE);
  assign muldiv_result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random operations
// compared against a plain-arithmetic RV64M reference model.
module tb_muldiv_unit;

  localparam logic [1:0] C_DEF = 2'b00;
  localparam logic [1:0] C_BLK = 2'b01;
  localparam logic [1:0] C_BUB = 2'b10;
  localparam logic [1:0] C_BRA = 2'b11;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ctrl = C_DEF;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic        word_i = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        busy, ready;
  logic [63:0] result;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [63:0] last_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(64)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .ctrl_signal_muldiv_i (ctrl),
    .muldiv_start_i       (start),
    .muldiv_op_i          (op_i),
    .muldiv_word_i        (word_i),
    .muldiv_src1_i        (src1),
    .muldiv_src2_i        (src2),
    .muldiv_busy_o        (busy),
    .muldiv_ready_o       (ready),
    .muldiv_result_o      (result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, sbu, sp;
    logic [127:0]        ua, ub, up;
    logic signed [63:0]  s64a, s64b;
    logic signed [31:0]  s32a, s32b;
    logic [31:0]         u32a, u32b, r32;
    logic [63:0]         r;
    sa = $signed(a); sb = $signed(b); sbu = $signed({64'b0, b});
    ua = {64'b0, a}; ub = {64'b0, b};
    s64a = a; s64b = b;
    s32a = a[31:0]; s32b = b[31:0]; u32a = a[31:0]; u32b = b[31:0];
    r = '0; r32 = '0;
    if (w) begin
      case (op)
        3'b000: r32 = u32a * u32b;
        3'b100: r32 = (s32b == 0) ? 32'hFFFF_FFFF :
                      (s32a == -32'sd2147483648 && s32b == -32'sd1) ? u32a : 32'(s32a / s32b);
        3'b101: r32 = (u32b == 0) ? 32'hFFFF_FFFF : u32a / u32b;
        3'b110: r32 = (s32b == 0) ? u32a :
                      (s32a == -32'sd2147483648 && s32b == -32'sd1) ? 32'h0 : 32'(s32a % s32b);
        3'b111: r32 = (u32b == 0) ? u32a : u32a % u32b;
        default: r32 = '0;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        3'b000: begin up = ua * ub; r = up[63:0]; end
        3'b001: begin sp = sa * sb; r = sp[127:64]; end
        3'b010: begin sp = sa * sbu; r = sp[127:64]; end
        3'b011: begin up = ua * ub; r = up[127:64]; end
        3'b100: r = (b == 0) ? '1 : (a == MIN64 && b == '1) ? a : 64'(s64a / s64b);
        3'b101: r = (b == 0) ? '1 : a / b;
        3'b110: r = (b == 0) ? a : (a == MIN64 && b == '1) ? 64'h0 : 64'(s64a % s64b);
        default: r = (b == 0) ? a : a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic w,
                                     input logic [63:0] a, input logic [63:0] b);
    logic zero, ovf;
    zero = w ? (b[31:0] == 32'h0) : (b == 64'h0);
    ovf  = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
             : (a == MIN64 && b == 64'hFFFF_FFFF_FFFF_FFFF);
    if (op[2] && (zero || (!op[0] && ovf))) return 1;
    return w ? 33 : 65;
  endfunction

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return '1;
      2: return MIN64;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20)) - 64'd10;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [2:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input int blk_at, input int blk_len);
    logic [63:0] exp_res;
    int exp_l, cyc;
    exp_res = ref_result(op, w, a, b);
    exp_l   = ref_latency(op, w, a, b) + blk_len;
    @(negedge clk);
    ctrl = C_DEF; start = 1'b1; op_i = op; word_i = w; src1 = a; src2 = b;
    #1 check({tag, " busy@accept"}, {63'b0, busy}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      ctrl = (blk_len > 0 && cyc >= blk_at && cyc < blk_at + blk_len) ? C_BLK : C_DEF;
    end while (!ready && cyc < 300);
    check({tag, " latency"}, 64'(cyc), 64'(exp_l));
    check({tag, " result"}, result, exp_res);
    check({tag, " busy@ready"}, {63'b0, busy}, 64'd0);
    ctrl = C_DEF;
    @(negedge clk);
    check({tag, " ready pulse"}, {63'b0, ready}, 64'd0);
    last_res = exp_res;
  endtask

  initial begin
    logic [2:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", {63'b0, ready}, 64'd0);
    check("rst result", result, 64'd0);
    check("rst busy", {63'b0, busy}, 64'd0);
    @(negedge clk) rst = 1'b1;

    // Directed multiplies
    do_op("mul 7*-3", 3'b000, 1'b0, 64'd7, -64'sd3, 0, 0);
    do_op("mulhu max*max", 3'b011, 1'b0, '1, '1, 0, 0);
    do_op("mulh -1*-1", 3'b001, 1'b0, '1, '1, 0, 0);

    // Divide by zero and overflow
    do_op("divu 100/0", 3'b101, 1'b0, 64'd100, 64'd0, 0, 0);
    do_op("rem -5/0", 3'b110, 1'b0, -64'sd5, 64'd0, 0, 0);
    do_op("divw x/0", 3'b100, 1'b1, 64'h1_0000_0005, 64'd0, 0, 0);
    do_op("div ovf", 3'b100, 1'b0, MIN64, '1, 0, 0);
    do_op("rem ovf", 3'b110, 1'b0, MIN64, '1, 0, 0);
    do_op("divw ovf", 3'b100, 1'b1, 64'h8000_0000, '1, 0, 0);

    // Word ops
    do_op("divw -7/2", 3'b100, 1'b1, -64'sd7, 64'd2, 0, 0);
    do_op("remw -7/2", 3'b110, 1'b1, -64'sd7, 64'd2, 0, 0);

    // Block for 10 cycles mid-operation
    do_op("divu blk", 3'b101, 1'b0, 64'd1000, 64'd7, 20, 10);

    // Start together with Bubble must not be accepted
    @(negedge clk);
    ctrl = C_BUB; start = 1'b1; op_i = 3'b000; word_i = 1'b0; src1 = 64'd5; src2 = 64'd6;
    #1 check("bubble busy", {63'b0, busy}, 64'd0);
    @(posedge clk);
    #1 start = 1'b0; ctrl = C_DEF;
    repeat (3) @(negedge clk);
    check("bubble no ready", {63'b0, ready}, 64'd0);
    check("bubble no busy", {63'b0, busy}, 64'd0);

    // Branch abort at cycle 30 of a MUL
    @(negedge clk);
    ctrl = C_DEF; start = 1'b1; op_i = 3'b000; word_i = 1'b0; src1 = 64'd123; src2 = 64'd456;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    ctrl = C_BRA;
    @(posedge clk);
    #1;
    check("abort ready", {63'b0, ready}, 64'd0);
    check("abort busy", {63'b0, busy}, 64'd0);
    check("abort result kept", result, last_res);
    ctrl = C_DEF;
    do_op("mul 3*4 after abort", 3'b000, 1'b0, 64'd3, 64'd4, 0, 0);

    // Asynchronous reset in the middle of a divide
    @(negedge clk);
    ctrl = C_DEF; start = 1'b1; op_i = 3'b101; word_i = 1'b0; src1 = 64'd999; src2 = 64'd10;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst ready", {63'b0, ready}, 64'd0);
    check("async rst busy", {63'b0, busy}, 64'd0);
    check("async rst result", result, 64'd0);
    @(negedge clk) rst = 1'b1;
    last_res = '0;

    // Random operations against the reference model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      rw  = (rop == 3'b000 || rop[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
      ra  = rand_operand();
      rb  = rand_operand();
      do_op($sformatf("rand%0d op%0d w%0d", i, rop, rw), rop, rw, ra, rb, 0, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV64M multiply/divide unit hosted by the EX stage.
- It is the responder side of the pipeline controller's EX-block handshake:
  - While an operation runs, it drives the busy flag that EX forwards as ex_block_flag.
  - When the result is final, it drives the ready pulse the controller consumes as muldiv_ready_i.
  - It obeys the controller's ctrl_signal_muldiv command bus: Default, Block, Bubble, Branch.
- Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 64, datapath width; 32-bit word ops always use the low 32 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ctrl_signal_muldiv_i  in  `CTRL_Wire_Bus  controller command; `CTRL_STATE_Default / _Block / _Bubble / _Branch.
- muldiv_start_i  in  1  EX holds an M-extension instruction.
- muldiv_op_i  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- muldiv_word_i  in  1  W variant; legal only with MUL, DIV, DIVU, REM, REMU.
- muldiv_src1_i  in  XLEN  rs1 operand.
- muldiv_src2_i  in  XLEN  rs2 operand.
- muldiv_busy_o  out  1  operation pending; EX must block.
- muldiv_ready_o  out  1  result valid this cycle.
- muldiv_result_o  out  XLEN  registered result.

Behaviour:
- Reset (rst=0, async): state IDLE, counter 0, muldiv_ready_o=0, muldiv_result_o=0, internal operand and accumulator registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - An operation is accepted when muldiv_start_i=1 and ctrl=Default.
  - On acceptance, capture operands and op, then go to CALC with N iterations: N=XLEN, or 32 when word=1.
  - Operand capture: signed ops take absolute values and record result signs. Word ops first sign-extend (signed) or zero-extend (unsigned) bits [31:0].
- CALC:
  - ctrl=Default: one iteration per cycle; counter decrements; after the N-th iteration go to DONE.
  - ctrl=Block: freeze all state, including counter and partial results.
- DONE:
  - Apply sign fixup (two's-complement negate) and select the result:
    - MUL: low XLEN bits of the product.
    - MULH, MULHSU, MULHU: high XLEN bits.
    - DIV/DIVU: quotient. REM/REMU: remainder.
    - Word ops: result = sign-extend(bits [31:0]).
  - Register the result into muldiv_result_o.
  - muldiv_ready_o=1 for exactly the DONE cycle(s); return to IDLE on the next edge if ctrl=Default.
  - If ctrl=Block, hold DONE with ready high.
- Latency, counting the accept edge as cycle 0: ready at cycle N+1, i.e. 65 for 64-bit ops and 33 for word ops, excluding Block cycles.
- Special cases, decided at accept: the unit goes straight to DONE, with ready at cycle 1.
  - Divide by zero: quotient = all ones; remainder = dividend (word-extended for W ops).
  - Signed overflow (most-negative / -1, at the operative width): quotient = dividend; remainder = 0.
- muldiv_busy_o (combinational) = (state==CALC) | (state==IDLE & muldiv_start_i & ctrl==Default). It is 0 in DONE, so the controller leaves EXBlock on the ready cycle.
- Abort: ctrl=Bubble or Branch in any state forces IDLE on the next edge.
  - muldiv_ready_o drops; muldiv_result_o keeps its previous value.
  - Start in the same cycle as Bubble/Branch is not accepted.
- Start in CALC/DONE is ignored; no queuing.
- muldiv_result_o changes only on DONE entry or reset.
- Signed arithmetic uses a 2*XLEN accumulator; all widths are explicit, with no truncation before the final select.

Test Plan:
- MUL src1=7, src2=-3, ctrl Default:
  - busy=1 in the accept cycle.
  - ready=1 only at cycle 65; result 0xFFFFFFFFFFFFFFEB.
  - busy=0 in the ready cycle.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × same → result 0xFFFFFFFFFFFFFFFE. MULH of same (−1×−1) → 0x0.
- Divide by zero:
  - DIVU 100/0 → 0xFFFFFFFFFFFFFFFF, ready at cycle 1.
  - REM −5/0 → 0xFFFFFFFFFFFFFFFB.
  - DIVW 0x1_0000_0005/0 → 0xFFFFFFFFFFFFFFFF.
- Overflow:
  - DIV 0x8000000000000000 / −1 → 0x8000000000000000; REM → 0.
  - DIVW 0x80000000 / −1 → 0xFFFFFFFF80000000.
- Word ops:
  - DIVW −7/2 → 0xFFFFFFFFFFFFFFFD, ready at cycle 33.
  - REMW −7/2 → 0xFFFFFFFFFFFFFFFF.
- Block/abort/reset:
  - Block for 10 cycles from cycle 20 of a DIVU 1000/7 → ready at cycle 75, result 142.
  - Branch at cycle 30 of a MUL → IDLE, no ready pulse, result_o unchanged; an immediate new MUL 3×4 → 12 at cycle 65.
  - rst low at cycle 40 → all outputs 0 asynchronously.
